// File: rtl/multi_timer_if.sv
// rtl/multi_timer_if.sv - CPU peripheral bus bundle for the multi-channel timer
interface multi_timer_if #(
  parameter int CH_BITS = 2
) ();
  logic [CH_BITS+1:0] Addr;
  logic [31:0]        Wd;
  logic               We;
  logic [31:0]        Rd;

  modport master (output Addr, output Wd, output We, input Rd);
  modport slave  (input Addr, input Wd, input We, output Rd);
endinterface

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - NUM_CH independent prescaled down-counting timers with masked interrupts
module multi_timer #(
  parameter int CH_BITS = 2,
  parameter int WIDTH   = 32,
  parameter int PS_BITS = 8
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  multi_timer_if.slave          bus,
  output logic [2**CH_BITS-1:0] IRQ_vec,
  output logic                  IRQ
);
  localparam int NUM_CH = 2**CH_BITS;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t               state_q  [NUM_CH];
  logic [1:0]           mode_q   [NUM_CH];
  logic [PS_BITS-1:0]   ps_q     [NUM_CH];
  logic [PS_BITS-1:0]   pre_q    [NUM_CH];
  logic [WIDTH-1:0]     preset_q [NUM_CH];
  logic [WIDTH-1:0]     count_q  [NUM_CH];
  logic [NUM_CH-1:0]    en_q;
  logic [NUM_CH-1:0]    im_q;
  logic [NUM_CH-1:0]    ir_q;

  logic [NUM_CH-1:0]    sel;
  logic [NUM_CH-1:0]    tick;
  logic [CH_BITS-1:0]   ch;
  logic [1:0]           rsel;
  logic [31:0]          rd_data;
  logic                 unused_wd;

  assign ch        = bus.Addr[CH_BITS+1:2];
  assign rsel      = bus.Addr[1:0];
  // Only the low Wd bits map onto fields; the rest are don't-care.
  assign unused_wd = ^bus.Wd;

  // Per-channel write select and prescaler tick compare
  always_comb begin
    sel  = '0;
    tick = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel[i]  = bus.We && (ch == CH_BITS'(i));
      tick[i] = (pre_q[i] == ps_q[i]);
    end
  end

  // Channel FSMs; bus writes are applied after the FSM so a CTRL write wins over
  // the one-shot Enable clear, and the IR set is applied after the W1C so set wins.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      en_q <= '0;
      im_q <= '0;
      ir_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= S_IDLE;
        mode_q[i]   <= 2'b00;
        ps_q[i]     <= '0;
        pre_q[i]    <= '0;
        preset_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel[i] && rsel == REG_STATUS && bus.Wd[0]) ir_q[i] <= 1'b0;

        case (state_q[i])
          S_IDLE: if (en_q[i]) state_q[i] <= S_LOAD;
          S_LOAD: begin
            count_q[i] <= preset_q[i];
            pre_q[i]   <= '0;
            state_q[i] <= S_CNT;
          end
          S_CNT: begin
            if (!en_q[i]) begin
              state_q[i] <= S_IDLE;
            end else if (tick[i]) begin
              pre_q[i] <= '0;
              if (count_q[i] > WIDTH'(1)) begin
                count_q[i] <= count_q[i] - WIDTH'(1);
              end else begin
                count_q[i] <= '0;
                ir_q[i]    <= 1'b1;
                state_q[i] <= S_INT;
              end
            end else begin
              pre_q[i] <= pre_q[i] + PS_BITS'(1);
            end
          end
          S_INT: begin
            if (mode_q[i] == 2'b01) begin
              state_q[i] <= S_LOAD;
            end else begin
              en_q[i]    <= 1'b0;
              state_q[i] <= S_IDLE;
            end
          end
          default: state_q[i] <= S_IDLE;
        endcase

        if (sel[i] && rsel == REG_CTRL) begin
          en_q[i]   <= bus.Wd[0];
          mode_q[i] <= bus.Wd[2:1];
          im_q[i]   <= bus.Wd[3];
          ps_q[i]   <= bus.Wd[4 +: PS_BITS];
        end
        if (sel[i] && rsel == REG_PRESET) preset_q[i] <= bus.Wd[WIDTH-1:0];
      end
    end
  end

  // Combinational register read, zero-extended to 32 bits
  always_comb begin
    rd_data = '0;
    case (rsel)
      REG_CTRL: begin
        rd_data[0]            = en_q[ch];
        rd_data[2:1]          = mode_q[ch];
        rd_data[3]            = im_q[ch];
        rd_data[4 +: PS_BITS] = ps_q[ch];
      end
      REG_PRESET: rd_data[WIDTH-1:0] = preset_q[ch];
      REG_COUNT:  rd_data[WIDTH-1:0] = count_q[ch];
      REG_STATUS: rd_data[0]         = ir_q[ch];
      default:    rd_data            = '0;
    endcase
  end

  assign bus.Rd  = rd_data;
  assign IRQ_vec = ir_q & im_q;
  assign IRQ     = |IRQ_vec;
endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Parametrised successor to the single-channel bus timer: NUM_CH independent down-counting channels of WIDTH bits.
- Each channel has a prescaler, one-shot and auto-reload modes, a sticky write-1-to-clear interrupt flag and a per-channel interrupt mask.
- Sits on the CPU peripheral bus behind the bridge; drives per-channel and combined interrupt lines to the CP0 interrupt inputs.

Parameters:
- CH_BITS, 2, log2 of the channel count; NUM_CH = 2**CH_BITS.
- WIDTH, 32, counter and preset width (1..32); read data is zero-extended to 32 bits.
- PS_BITS, 8, prescaler field width (1..16).

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Addr  input  CH_BITS+2  word address = {channel, reg}; reg 0 CTRL, 1 PRESET, 2 COUNT, 3 STATUS.
- Wd  input  32  write data.
- We  input  1  write strobe, one cycle per write.
- Rd  output  32  combinational read data for the register at Addr.
- IRQ_vec  output  NUM_CH  per-channel interrupt: IR[i] & IM[i].
- IRQ  output  1  OR of IRQ_vec.

Behaviour:
- Reset (Reset_n=0, asynchronous): every channel goes to IDLE with CTRL, PRESET, COUNT, prescaler and IR all 0. IRQ_vec=0, IRQ=0.
- CTRL layout: [0] Enable, [2:1] Mode, [3] IM, [4+PS_BITS-1:4] PS. Other bits read 0.
- Modes: 00 one-shot, 01 auto-reload. 10 and 11 behave as 00 but read back as written.
- STATUS: [0] IR; writing 1 to bit 0 clears it. COUNT is read-only; writes to it are ignored.
- PRESET: write of Wd[WIDTH-1:0] takes effect at the next LOAD, never mid-count.
- Tick: a per-channel prescaler runs only in CNT. tick=1 when prescaler==PS, and the prescaler then wraps to 0. PS=0 gives a tick every cycle; PS=n gives a tick every n+1 cycles.
- Per-channel FSM, one transition per clock:
  - IDLE: if Enable, go to LOAD. IR is not cleared.
  - LOAD: COUNT<=PRESET, prescaler<=0, go to CNT.
  - CNT: if !Enable, go to IDLE with COUNT frozen. Else on tick:
    - COUNT>1: COUNT-1.
    - COUNT<=1: COUNT<=0, IR<=1, go to INT.
  - INT: Mode 01 goes to LOAD. Otherwise Enable<=0 and go to IDLE.
- Latency, PS=0, auto-reload: Enable written at edge 0 → LOAD at edge 1 → COUNT=P after edge 2 → IR=1 after edge P+2. Period is P+2 cycles.
- PRESET=0: expires on the first tick in CNT, identical to PRESET=1.
- A bus write affects only the addressed channel in that cycle; all other channels keep running.
- A CTRL write to a channel in CNT or INT takes effect immediately. Enable=0 forces IDLE on the next edge. A PS change applies from the next tick compare, and the prescaler is not reset.
- IR set and W1C clear in the same cycle: set wins, IR=1.
- IM=0 masks IRQ_vec only. IR still sets and is still readable.
- Reset asserted mid-count: all state cleared immediately, with no IRQ glitch after deassertion.
- Rd for COUNT shows the value before the current edge's update.

Test Plan:
- Reset, then read all 4·NUM_CH registers → all 0; IRQ=0.
- Ch0: PRESET=5, CTRL=0x9 (IM=1, one-shot, Enable) → IRQ_vec[0] rises 7 cycles after the write edge; COUNT reads 0; CTRL reads 0x8; STATUS=1. Write STATUS=1 → IRQ drops next cycle.
- Ch1: PRESET=3, CTRL=0x2B (PS=2, auto-reload, IM, Enable) → COUNT steps every 3 cycles. IR sets, is cleared by W1C and sets again one full period later. A PRESET=10 write mid-count applies only after the next reload.
- Ch2 counting while ch3 receives back-to-back writes → ch2 COUNT sequence is undisturbed. Ch2 CTRL=0 mid-count → COUNT frozen at its current value, state IDLE, no IR.
- W1C write on the exact expiry cycle → STATUS=1 afterwards. IM=0 with an expired channel → STATUS=1 but IRQ=0.
- Assert Reset_n low between clock edges mid-count → all outputs 0 immediately. After release and re-enable with PRESET=0 → IR after 3 cycles.
